// File: rtl/frame_read_index_if.sv
// Handshake/bus bundle between the read DMA side and frame_read_index.
// The master drives vsyncs and control; the slave returns read addresses and status.
interface frame_read_index_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 28
);
  logic [NUM_CH-1:0]        wr_vs;
  logic                     rd_vs;
  logic                     rd_frame_done;
  logic [NUM_CH-1:0]        rd_freeze;
  logic                     ovr_clr;
  logic [NUM_CH*ADDR_W-1:0] read_BaseDdr_addr;
  logic [NUM_CH-1:0]        rd_valid;
  logic                     rd_busy;
  logic [NUM_CH-1:0]        rd_overrun;

  modport master (
    output wr_vs, rd_vs, rd_frame_done, rd_freeze, ovr_clr,
    input  read_BaseDdr_addr, rd_valid, rd_busy, rd_overrun
  );

  modport slave (
    input  wr_vs, rd_vs, rd_frame_done, rd_freeze, ovr_clr,
    output read_BaseDdr_addr, rd_valid, rd_busy, rd_overrun
  );
endinterface

// File: rtl/frame_read_index.sv
// Read-side frame slot tracker: mirrors each writer's 4-slot rotation and
// latches the latest completed slot per channel on every read vsync.
module frame_read_index #(
  parameter int                NUM_CH       = 4,
  parameter int                ADDR_W       = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 28'h0000000,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = 28'h0400000,
  parameter logic [ADDR_W-1:0] CH_STRIDE    = 28'h1000000
) (
  input  logic               axi_aclk,
  input  logic               axi_areset,
  frame_read_index_if.slave  bus
);

  logic [NUM_CH-1:0]        r_wr_d1, r_wr_d2;
  logic                     r_rd_d1, r_rd_d2;
  logic [NUM_CH-1:0][1:0]   r_wr_idx, r_slot;
  logic [NUM_CH-1:0]        r_done, r_valid, r_ovr;
  logic                     r_busy;
  logic [NUM_CH*ADDR_W-1:0] r_addr;

  logic [NUM_CH-1:0]        w_wr_pos;
  logic                     w_rd_pos;
  logic [NUM_CH-1:0][1:0]   w_idx_nxt, w_slot_nxt;
  logic [NUM_CH-1:0]        w_latch, w_valid_nxt, w_ovr_set, w_ovr_nxt;
  logic                     w_busy_nxt;
  logic [NUM_CH*ADDR_W-1:0] w_addr, w_addr_rst;

  assign w_wr_pos = r_wr_d1 & ~r_wr_d2;
  assign w_rd_pos = r_rd_d1 & ~r_rd_d2;

  always_comb begin
    w_idx_nxt  = r_wr_idx;
    w_slot_nxt = r_slot;
    w_latch    = '0;
    w_ovr_set  = '0;
    w_addr     = '0;
    w_addr_rst = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_idx_nxt[c] = r_wr_idx[c] + {1'b0, w_wr_pos[c]};
      // a writer edge in the latch cycle means its current slot just finished
      w_latch[c] = w_rd_pos & (r_done[c] | w_wr_pos[c]) & ~bus.rd_freeze[c];
      if (w_latch[c])
        w_slot_nxt[c] = w_wr_pos[c] ? r_wr_idx[c] : r_wr_idx[c] - 2'd1;
      w_ovr_set[c] = w_wr_pos[c] & r_busy & r_valid[c] &
                     ((r_wr_idx[c] + 2'd1) == r_slot[c]);
      w_addr_rst[c*ADDR_W +: ADDR_W] = BASE_ADDR + ADDR_W'(c) * CH_STRIDE;
      w_addr[c*ADDR_W +: ADDR_W] = BASE_ADDR + ADDR_W'(c) * CH_STRIDE +
                                   ADDR_W'(r_slot[c]) * FRAME_STRIDE;
    end
  end

  assign w_valid_nxt = r_valid | w_latch;
  assign w_ovr_nxt   = (bus.ovr_clr ? '0 : r_ovr) | w_ovr_set;

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_rd_pos && (|w_valid_nxt))
      w_busy_nxt = 1'b1;
    else if (bus.rd_frame_done)
      w_busy_nxt = 1'b0;
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_wr_d1  <= '0;
      r_wr_d2  <= '0;
      r_rd_d1  <= 1'b0;
      r_rd_d2  <= 1'b0;
      r_wr_idx <= '0;
      r_slot   <= '0;
      r_done   <= '0;
      r_valid  <= '0;
      r_ovr    <= '0;
      r_busy   <= 1'b0;
      r_addr   <= w_addr_rst;
    end else begin
      r_wr_d1  <= bus.wr_vs;
      r_wr_d2  <= r_wr_d1;
      r_rd_d1  <= bus.rd_vs;
      r_rd_d2  <= r_rd_d1;
      r_wr_idx <= w_idx_nxt;
      r_slot   <= w_slot_nxt;
      r_done   <= r_done | w_wr_pos;
      r_valid  <= w_valid_nxt;
      r_ovr    <= w_ovr_nxt;
      r_busy   <= w_busy_nxt;
      r_addr   <= w_addr;
    end
  end

  assign bus.read_BaseDdr_addr = r_addr;
  assign bus.rd_valid          = r_valid;
  assign bus.rd_busy           = r_busy;
  assign bus.rd_overrun        = r_ovr;

endmodule

// File: tb/tb_frame_read_index.sv
// Scoreboard bench for frame_read_index: stimulus queues expected state,
// a negedge monitor pops and compares against the DUT outputs.
module tb_frame_read_index;

  logic clk;
  logic rst;

  frame_read_index_if #(.NUM_CH(4), .ADDR_W(28)) bus ();

  frame_read_index dut (
    .axi_aclk   (clk),
    .axi_areset (rst),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [111:0] addr;
    logic [3:0]   valid;
    logic         busy;
    logic [3:0]   ovr;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   es[4];

  function automatic logic [111:0] build();
    logic [111:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      r[c*28 +: 28] = 28'(c) * 28'h1000000 + 28'(es[c]) * 28'h0400000;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [3:0] v,
                     input logic b, input logic [3:0] o);
    exp_t e;
    e.name  = nm;
    e.addr  = build();
    e.valid = v;
    e.busy  = b;
    e.ovr   = o;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (bus.read_BaseDdr_addr !== e.addr || bus.rd_valid !== e.valid ||
          bus.rd_busy !== e.busy || bus.rd_overrun !== e.ovr) begin
        n_fail++;
        $display("FAIL %s: got addr=%h valid=%b busy=%b ovr=%b, want addr=%h valid=%b busy=%b ovr=%b",
                 e.name, bus.read_BaseDdr_addr, bus.rd_valid, bus.rd_busy,
                 bus.rd_overrun, e.addr, e.valid, e.busy, e.ovr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] w, input logic r);
    bus.wr_vs = w;
    bus.rd_vs = r;
    tick();
    tick();
    bus.wr_vs = '0;
    bus.rd_vs = 1'b0;
    repeat (4) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) es[c] = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst               = 1'b1;
    bus.wr_vs         = '0;
    bus.rd_vs         = 1'b0;
    bus.rd_frame_done = 1'b0;
    bus.rd_freeze     = '0;
    bus.ovr_clr       = 1'b0;
    for (int c = 0; c < 4; c++) es[c] = 0;
    do_reset();
    chk("reset", 4'b0000, 1'b0, 4'b0000);

    // rd_vs with no completed frame
    pulse(4'b0000, 1'b1);
    chk("rd_before_wr", 4'b0000, 1'b0, 4'b0000);

    // three ch0 frames, then read: slot 2, addr 0x0800000
    repeat (3) pulse(4'b0001, 1'b0);
    bus.rd_vs = 1'b1;
    tick();
    chk("lat_edge1", 4'b0000, 1'b0, 4'b0000);
    tick();
    chk("lat_edge2", 4'b0001, 1'b1, 4'b0000);
    tick();
    es[0] = 2;
    chk("lat_edge3", 4'b0001, 1'b1, 4'b0000);
    bus.rd_vs = 1'b0;
    repeat (4) tick();

    // ch3 one frame done, then writer and reader edges together
    pulse(4'b1000, 1'b0);
    pulse(4'b1000, 1'b1);
    es[3] = 1;
    chk("same_cycle_ch3", 4'b1001, 1'b1, 4'b0000);

    // edges apart from reset: slot 0
    do_reset();
    pulse(4'b1000, 1'b0);
    pulse(4'b0000, 1'b1);
    es[3] = 0;
    chk("apart_ch3", 4'b1000, 1'b1, 4'b0000);

    // ch1 overrun on the wrap 3->0 against read slot 0
    do_reset();
    pulse(4'b0010, 1'b0);
    pulse(4'b0000, 1'b1);
    chk("ch1_latch", 4'b0010, 1'b1, 4'b0000);
    pulse(4'b0010, 1'b0);
    pulse(4'b0010, 1'b0);
    chk("ch1_no_ovr_yet", 4'b0010, 1'b1, 4'b0000);
    pulse(4'b0010, 1'b0);
    chk("ch1_ovr", 4'b0010, 1'b1, 4'b0010);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    tick();
    chk("ovr_clr", 4'b0010, 1'b1, 4'b0000);

    // same sequence after frame done: no overrun
    do_reset();
    pulse(4'b0010, 1'b0);
    pulse(4'b0000, 1'b1);
    bus.rd_frame_done = 1'b1;
    tick();
    bus.rd_frame_done = 1'b0;
    tick();
    chk("frame_done", 4'b0010, 1'b0, 4'b0000);
    repeat (3) pulse(4'b0010, 1'b0);
    chk("idle_no_ovr", 4'b0010, 1'b0, 4'b0000);

    // rd_pos coinciding with frame_done keeps busy; ch1 idx 0 -> slot 3
    bus.rd_vs = 1'b1;
    tick();
    bus.rd_frame_done = 1'b1;
    tick();
    bus.rd_frame_done = 1'b0;
    bus.rd_vs = 1'b0;
    repeat (4) tick();
    es[1] = 3;
    chk("pos_and_done", 4'b0010, 1'b1, 4'b0000);

    // ch2 freeze across 5 reads while its writer keeps rotating
    pulse(4'b0100, 1'b0);
    pulse(4'b0000, 1'b1);
    es[2] = 0;
    chk("ch2_latch", 4'b0110, 1'b1, 4'b0000);
    bus.rd_freeze = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      pulse(4'b0100, 1'b0);
      pulse(4'b0000, 1'b1);
      chk($sformatf("freeze_%0d", i), 4'b0110, 1'b1,
          (i >= 2) ? 4'b0100 : 4'b0000);
    end
    bus.rd_freeze = 4'b0000;
    pulse(4'b0000, 1'b1);
    es[2] = 1;
    chk("unfreeze", 4'b0110, 1'b1, 4'b0100);

    // reset mid-frame with busy and overrun set
    bus.rd_vs = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) es[c] = 0;
    chk("mid_reset", 4'b0000, 1'b0, 4'b0000);
    rst = 1'b0;
    bus.rd_vs = 1'b0;
    tick();

    // wrap 3->0 after reset: idx 0 -> read slot 3
    repeat (4) pulse(4'b0001, 1'b0);
    pulse(4'b0000, 1'b1);
    es[0] = 3;
    chk("wrap_after_reset", 4'b0001, 1'b1, 4'b0000);

    repeat (2) tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_read_index.md
Name: frame_read_index

Overview:
- Read-side counterpart to the per-source write frame-buffer rotation.
- Mirrors each writer's 4-slot DDR frame index from that writer's vsync.
- On every display/read vsync, latches the most recently completed slot per channel and outputs registered DDR read base addresses for the read DMA.
- Flags writer overruns into the slot currently being read.

Parameters:
NUM_CH, 4, number of video sources (fixed 4 in this revision)
ADDR_W, 28, DDR address width
BASE_ADDR, 28'h0000000, address of channel 0, slot 0
FRAME_STRIDE, 28'h0400000, byte distance between slots of one channel
CH_STRIDE, 28'h1000000, byte distance between channels

Ports:
axi_aclk  in  1  system clock
axi_areset  in  1  synchronous reset, active-high
wr_vs  in  4  writer vsync per channel (bit0 cmos1, bit1 cmos2, bit2 hdmi_in, bit3 udp_in); asynchronous
rd_vs  in  1  read/display vsync; asynchronous
rd_frame_done  in  1  one-cycle pulse from read DMA when a frame read completes; axi_aclk domain
rd_freeze  in  4  level; per-channel hold of the current read slot
ovr_clr  in  1  pulse; clears rd_overrun
read_BaseDdr_addr  out  4*ADDR_W  channel c occupies bits [c*ADDR_W +: ADDR_W]
rd_valid  out  4  channel has at least one completed frame latched
rd_busy  out  1  read frame in progress
rd_overrun  out  4  sticky writer-into-read-slot flags

Behaviour:
- Synchronisers: each wr_vs bit and rd_vs pass through 2 flops (d1, d2). Edge detect pos = d1 & ~d2. Reset clears all flops.
- Writer mirror: per channel, wr_idx[c] is 2 bits, reset 0, +1 (mod 4) on wr_pos[c]. This matches the writer rotation exactly.
- Completed flag: done_ok[c] (internal), reset 0, set on the first wr_pos[c]. The completed slot is wr_idx-1.
- Read latch: on rd_pos, for each c with done_ok[c]=1 and rd_freeze[c]=0:
  - rd_slot[c] <= wr_idx[c]-1 normally.
  - If wr_pos[c] fires in the same cycle, rd_slot[c] <= wr_idx[c] (the frame just finished).
  - rd_valid[c] <= 1.
  - Channels with done_ok=0 or frozen keep rd_slot and rd_valid.
- First-frame edge case: done_ok[c]=0 but wr_pos[c] and rd_pos in the same cycle gives rd_slot[c]=0 and rd_valid[c]=1.
- Address register:
  - read_BaseDdr_addr[c] = BASE_ADDR + c*CH_STRIDE + rd_slot[c]*FRAME_STRIDE.
  - Registered, so it updates one cycle after rd_slot.
  - Total latency: the address changes on the 3rd rising axi_aclk edge after rd_vs is first sampled high.
  - Arithmetic is truncated to ADDR_W; no overflow check.
- rd_busy:
  - Reset 0.
  - Set on rd_pos when any rd_valid (post-update) is 1.
  - Cleared by rd_frame_done.
  - rd_pos and rd_frame_done in the same cycle: rd_busy = 1.
  - rd_frame_done while idle: ignored.
- Overrun:
  - On wr_pos[c] with rd_busy=1, rd_valid[c]=1 and (wr_idx[c]+1) mod 4 == rd_slot[c]: set rd_overrun[c].
  - The mirror still advances; this block never stalls the writer.
  - ovr_clr clears all bits. If set and clear coincide, set wins.
- Freeze: a frozen channel keeps its address across any number of rd_vs. Overrun checking continues while frozen.
- Reset (any time, mid-frame included):
  - wr_idx, rd_slot, done_ok, rd_valid, rd_busy and rd_overrun all go to 0.
  - read_BaseDdr_addr[c] = BASE_ADDR + c*CH_STRIDE.
  - Effective on the clock edge where axi_areset is sampled high.
- Multiple channels and rd_vs may edge in the same cycle; each is handled independently as above.

Test Plan:
1. Reset, then 3 wr_vs[0] pulses followed by 1 rd_vs pulse -> rd_slot0=2, addr0=28'h0800000, rd_valid=4'b0001, rd_busy=1. Addr changes exactly 3 clocks after rd_vs goes high.
2. rd_vs before any wr_vs -> rd_valid=0, rd_busy=0, all addresses at slot 0: 28'h0000000, 28'h1000000, 28'h2000000, 28'h3000000.
3. wr_idx3=1 (one frame done), then the wr_vs[3] edge and rd_vs edge synchronise to the same cycle -> rd_slot3=1, addr3=28'h3400000. Repeat with the edges apart -> rd_slot3=0.
4. Read slot 0 on ch1 with busy, then 3 more wr_vs[1] pulses (wr_idx 1->0 wrap) -> rd_overrun=4'b0010 on the third pulse. ovr_clr clears it. Same test with rd_frame_done first -> no overrun.
5. rd_freeze[2]=1 across 5 rd_vs with ongoing wr_vs[2] -> addr2 unchanged. Release freeze, next rd_vs -> latest completed slot.
6. Assert axi_areset mid-frame with rd_busy=1 and overrun set -> all outputs at reset values the next cycle; wr_idx wrap 3->0 verified after reset.
